// File: rtl/scan_sram_pkg.sv
// Shared definitions for the scan-chain SRAM port controller.
// Holds the FSM state encoding, field-offset constants and helpers that
// compute the scan frame geometry from the block parameters.
//
// Frame layout, MSB first:
//   {sel, port0{addr, din, csb, web, wmask}, port1{...}, ...}
// Inside one port slot, offsets are counted from the slot LSB (wmask).
package scan_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam int OFF_WMASK = 0;

    function automatic int port_w(input int addr_w, input int data_w, input int mask_w);
        return addr_w + data_w + 2 + mask_w;
    endfunction

    function automatic int scan_len(input int sel_w, input int num_ports,
                                    input int addr_w, input int data_w,
                                    input int mask_w);
        return sel_w + num_ports * port_w(addr_w, data_w, mask_w);
    endfunction

    // Port 0 sits directly below sel, so higher port numbers sit lower.
    function automatic int port_lsb(input int p, input int num_ports, input int pw);
        return (num_ports - 1 - p) * pw;
    endfunction

    function automatic int off_web(input int mask_w);
        return mask_w;
    endfunction

    function automatic int off_csb(input int mask_w);
        return mask_w + 1;
    endfunction

    function automatic int off_din(input int mask_w);
        return mask_w + 2;
    endfunction

    function automatic int off_addr(input int mask_w, input int data_w);
        return mask_w + 2 + data_w;
    endfunction

endpackage

// File: rtl/scan_frame_reg.sv
// Scan frame storage: serial shift register, saturating shift counter and
// parallel replacement of selected din fields with captured read data.
//
// Ports:
//   clk, reset_n  clock, async active-low reset
//   shift_en      shift frame left one bit, scan_in enters the LSB
//   scan_in       serial input
//   load_en       replace din field of every port flagged in load_mask
//   load_mask     per-port select for the parallel load
//   load_data     replacement din values, port p at [p*DATA_W +: DATA_W]
//   frame         full frame contents
//   frame_valid   a full SCAN_LEN bits have been shifted since the last load
module scan_frame_reg
    import scan_sram_pkg::*;
#(
    parameter int SEL_W     = 4,
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MASK_W    = 4,
    localparam int SCAN_LEN = scan_len(SEL_W, NUM_PORTS, ADDR_W, DATA_W, MASK_W)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        shift_en,
    input  logic                        scan_in,
    input  logic                        load_en,
    input  logic [NUM_PORTS-1:0]        load_mask,
    input  logic [NUM_PORTS*DATA_W-1:0] load_data,
    output logic [SCAN_LEN-1:0]         frame,
    output logic                        frame_valid
);

    localparam int PORT_W = port_w(ADDR_W, DATA_W, MASK_W);
    localparam int CNT_W  = $clog2(SCAN_LEN + 1);

    logic [SCAN_LEN-1:0] frame_q;
    logic [SCAN_LEN-1:0] frame_loaded;
    logic [CNT_W-1:0]    cnt_q;

    always_comb begin
        frame_loaded = frame_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (load_mask[p]) begin
                frame_loaded[port_lsb(p, NUM_PORTS, PORT_W) + off_din(MASK_W) +: DATA_W] =
                    load_data[p*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            frame_q <= {frame_q[SCAN_LEN-2:0], scan_in};
            if (cnt_q != CNT_W'(SCAN_LEN)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (load_en) begin
            // A load invalidates the frame until it has been fully shifted again.
            frame_q <= frame_loaded;
            cnt_q   <= '0;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = (cnt_q == CNT_W'(SCAN_LEN));

endmodule

// File: rtl/scan_sram_port_ctrl.sv
// Scan-driven SRAM port controller. A frame shifted in over scan_in
// describes one access per SRAM port; a falling edge on global_csb fires
// the access, read data is captured and can be loaded back into the frame
// for scan-out.
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   scan_en, scan_in   frame shift control / serial data
//   scan_out           frame MSB
//   sram_load          copy captured read data into the frame din fields
//   global_csb         active-low access strobe (falling edge triggers)
//   err_clr            clear sticky error flags
//   sram_*             SRAM macro port bundle, port p at slice p
//   busy               access in progress
//   err_frame          trigger seen with an incomplete frame (sticky)
//   err_busy           scan_en asserted while busy (sticky)
//   access_cnt         completed access count, wraps at 16 bits
//
// state    | meaning
// IDLE     | shifting / loading allowed, waiting for trigger
// ACCESS   | one cycle, frame fields driven onto the SRAM ports
// WAIT     | READ_LAT-1 cycles of read latency
// CAPTURE  | sram_dout registered for the read ports
module scan_sram_port_ctrl
    import scan_sram_pkg::*;
#(
    parameter int SEL_W     = 4,
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MASK_W    = 4,
    parameter int READ_LAT  = 1,
    parameter int AUTO_LOAD = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        scan_en,
    input  logic                        scan_in,
    output logic                        scan_out,
    input  logic                        sram_load,
    input  logic                        global_csb,
    input  logic                        err_clr,
    output logic [SEL_W-1:0]            sram_sel,
    output logic [NUM_PORTS-1:0]        sram_csb,
    output logic [NUM_PORTS-1:0]        sram_web,
    output logic [NUM_PORTS*MASK_W-1:0] sram_wmask,
    output logic [NUM_PORTS*ADDR_W-1:0] sram_addr,
    output logic [NUM_PORTS*DATA_W-1:0] sram_din,
    input  logic [NUM_PORTS*DATA_W-1:0] sram_dout,
    output logic                        busy,
    output logic                        err_frame,
    output logic                        err_busy,
    output logic [15:0]                 access_cnt
);

    localparam int SCAN_LEN  = scan_len(SEL_W, NUM_PORTS, ADDR_W, DATA_W, MASK_W);
    localparam int PORT_W    = port_w(ADDR_W, DATA_W, MASK_W);
    localparam int WAIT_W    = $clog2(READ_LAT + 1);
    localparam int WAIT_LOAD = (READ_LAT > 1) ? READ_LAT - 2 : 0;

    state_t state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q;

    logic csb_sync_q, csb_edge_q, csb_fall;
    logic idle, shift_req, trig, start, frame_err, load_req, auto_load, load_en;

    logic [SCAN_LEN-1:0]         frame;
    logic                        frame_valid;
    logic [SEL_W-1:0]            f_sel;
    logic [NUM_PORTS-1:0]        f_csb, f_web, read_mask;
    logic [NUM_PORTS*MASK_W-1:0] f_wmask;
    logic [NUM_PORTS*ADDR_W-1:0] f_addr;
    logic [NUM_PORTS*DATA_W-1:0] f_din;
    logic [NUM_PORTS*DATA_W-1:0] cap_q, cap_next, load_data;

    logic [SEL_W-1:0]            sel_q;
    logic [NUM_PORTS-1:0]        csb_q, web_q;
    logic [NUM_PORTS*MASK_W-1:0] wmask_q;
    logic [NUM_PORTS*ADDR_W-1:0] addr_q;
    logic [NUM_PORTS*DATA_W-1:0] din_q;
    logic                        err_frame_q, err_busy_q;
    logic [15:0]                 access_cnt_q;

    // Frame field extraction
    assign f_sel = frame[SCAN_LEN-1 -: SEL_W];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_field
        localparam int LSB = port_lsb(p, NUM_PORTS, PORT_W);
        assign f_wmask[p*MASK_W +: MASK_W] = frame[LSB + OFF_WMASK +: MASK_W];
        assign f_web[p]                    = frame[LSB + off_web(MASK_W)];
        assign f_csb[p]                    = frame[LSB + off_csb(MASK_W)];
        assign f_din[p*DATA_W +: DATA_W]   = frame[LSB + off_din(MASK_W) +: DATA_W];
        assign f_addr[p*ADDR_W +: ADDR_W]  = frame[LSB + off_addr(MASK_W, DATA_W) +: ADDR_W];
    end

    assign read_mask = ~f_csb & f_web;

    // Request decode; priority in IDLE is shift > trigger > load.
    assign csb_fall  = csb_edge_q & ~csb_sync_q;
    assign idle      = (state_q == ST_IDLE);
    assign shift_req = idle & scan_en;
    assign trig      = idle & ~scan_en & csb_fall;
    assign start     = trig & frame_valid;
    assign frame_err = trig & ~frame_valid;
    assign load_req  = idle & ~scan_en & ~csb_fall & sram_load & (AUTO_LOAD == 0);
    assign auto_load = (AUTO_LOAD != 0) && (state_q == ST_CAPTURE);
    assign load_en   = load_req | auto_load;

    always_comb begin
        cap_next = cap_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (read_mask[p]) begin
                cap_next[p*DATA_W +: DATA_W] = sram_dout[p*DATA_W +: DATA_W];
            end
        end
    end

    // Auto-load happens on the same edge that captures, so it takes the
    // freshly sampled dout rather than the not-yet-updated capture register.
    assign load_data = (state_q == ST_CAPTURE) ? cap_next : cap_q;

    scan_frame_reg #(
        .SEL_W     (SEL_W),
        .NUM_PORTS (NUM_PORTS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MASK_W    (MASK_W)
    ) u_frame (
        .clk         (clk),
        .reset_n     (reset_n),
        .shift_en    (shift_req),
        .scan_in     (scan_in),
        .load_en     (load_en),
        .load_mask   (read_mask),
        .load_data   (load_data),
        .frame       (frame),
        .frame_valid (frame_valid)
    );

    // FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ACCESS;
            ST_ACCESS:  state_d = (READ_LAT > 1) ? ST_WAIT : ST_CAPTURE;
            ST_WAIT:    if (wait_cnt_q == '0) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Read-latency down-counter, terminal count zero ends WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            wait_cnt_q <= WAIT_W'(WAIT_LOAD);
        end else if ((state_q == ST_WAIT) && (wait_cnt_q != '0)) begin
            wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
        end
    end

    // Strobe synchroniser and edge register; idle-high after reset so a
    // released reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csb_sync_q <= 1'b1;
            csb_edge_q <= 1'b1;
        end else begin
            csb_sync_q <= global_csb;
            csb_edge_q <= csb_sync_q;
        end
    end

    // SRAM port drive: registered so csb/web are active exactly in ACCESS,
    // while sel/addr/din/wmask hold between accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wmask_q <= '0;
            csb_q   <= '1;
            web_q   <= '1;
        end else if (start) begin
            sel_q   <= f_sel;
            addr_q  <= f_addr;
            din_q   <= f_din;
            wmask_q <= f_wmask;
            csb_q   <= f_csb;
            web_q   <= f_web;
        end else begin
            csb_q   <= '1;
            web_q   <= '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q        <= '0;
            access_cnt_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            cap_q        <= cap_next;
            access_cnt_q <= access_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_frame_q <= 1'b0;
            err_busy_q  <= 1'b0;
        end else begin
            if (frame_err)    err_frame_q <= 1'b1;
            else if (err_clr) err_frame_q <= 1'b0;
            if (~idle & scan_en) err_busy_q <= 1'b1;
            else if (err_clr)    err_busy_q <= 1'b0;
        end
    end

    assign scan_out   = frame[SCAN_LEN-1];
    assign sram_sel   = sel_q;
    assign sram_csb   = csb_q;
    assign sram_web   = web_q;
    assign sram_wmask = wmask_q;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;
    assign busy       = (state_q != ST_IDLE);
    assign err_frame  = err_frame_q;
    assign err_busy   = err_busy_q;
    assign access_cnt = access_cnt_q;

endmodule

// File: tb/tb_scan_sram_port_ctrl.sv
// Directed bench for scan_sram_port_ctrl. Instance 0 uses defaults
// (READ_LAT=1, manual load); instance 1 uses READ_LAT=3 with AUTO_LOAD=1.
// Each instance has its own stimulus and its own SRAM read model, which
// returns addr << (2*port) exactly READ_LAT cycles after a read access and
// a poison value at every other time.
module tb_scan_sram_port_ctrl;

    logic clk;
    logic rst_n      [2];
    logic scan_en    [2];
    logic scan_in    [2];
    logic scan_out   [2];
    logic sram_load  [2];
    logic gcsb       [2];
    logic err_clr    [2];
    logic [3:0]  sel_o   [2];
    logic [1:0]  csb_o   [2];
    logic [1:0]  web_o   [2];
    logic [7:0]  wmask_o [2];
    logic [31:0] addr_o  [2];
    logic [63:0] din_o   [2];
    logic [63:0] dout_i  [2];
    logic        busy    [2];
    logic        errf    [2];
    logic        errb    [2];
    logic [15:0] acnt    [2];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar w = 0; w < 2; w++) begin : g_dut
        scan_sram_port_ctrl #(
            .READ_LAT  ((w == 0) ? 1 : 3),
            .AUTO_LOAD ((w == 0) ? 0 : 1)
        ) dut (
            .clk        (clk),
            .reset_n    (rst_n[w]),
            .scan_en    (scan_en[w]),
            .scan_in    (scan_in[w]),
            .scan_out   (scan_out[w]),
            .sram_load  (sram_load[w]),
            .global_csb (gcsb[w]),
            .err_clr    (err_clr[w]),
            .sram_sel   (sel_o[w]),
            .sram_csb   (csb_o[w]),
            .sram_web   (web_o[w]),
            .sram_wmask (wmask_o[w]),
            .sram_addr  (addr_o[w]),
            .sram_din   (din_o[w]),
            .sram_dout  (dout_i[w]),
            .busy       (busy[w]),
            .err_frame  (errf[w]),
            .err_busy   (errb[w]),
            .access_cnt (acnt[w])
        );
    end

    // SRAM read model
    logic [63:0] pipe_d [2][3];
    logic [1:0]  pipe_v [2][3] = '{default: 2'b00};

    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            for (int s = 2; s > 0; s--) begin
                pipe_d[w][s] <= pipe_d[w][s-1];
                pipe_v[w][s] <= pipe_v[w][s-1];
            end
            for (int p = 0; p < 2; p++) begin
                pipe_v[w][0][p] <= !csb_o[w][p] && web_o[w][p];
                pipe_d[w][0][p*32 +: 32] <= {16'd0, addr_o[w][p*16 +: 16]} << (2*p);
            end
        end
    end

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            int s;
            s = (w == 0) ? 0 : 2;
            dout_i[w] = '0;
            for (int p = 0; p < 2; p++) begin
                dout_i[w][p*32 +: 32] = pipe_v[w][s][p] ? pipe_d[w][s][p*32 +: 32] : 32'hBAD0_BAD0;
            end
        end
    end

    function automatic logic [111:0] mk(
        input logic [3:0] sel,
        input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0, input logic [3:0] m0,
        input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1, input logic [3:0] m1);
        return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling clock edge.
    task automatic shift_in(input int w, input logic [111:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            scan_en[w] = 1'b1;
            scan_in[w] = f[i];
            @(negedge clk);
        end
        scan_en[w] = 1'b0;
        scan_in[w] = 1'b0;
    endtask

    task automatic read_out(input int w, output logic [111:0] f);
        for (int i = 111; i >= 0; i--) begin
            f[i]       = scan_out[w];
            scan_en[w] = 1'b1;
            scan_in[w] = 1'b0;
            @(negedge clk);
        end
        scan_en[w] = 1'b0;
    endtask

    task automatic pulse_csb(input int w);
        gcsb[w] = 1'b0;
        @(negedge clk);
        gcsb[w] = 1'b1;
    endtask

    logic [111:0] f_write, f_read, exp_f, got_f;

    initial begin
        for (int w = 0; w < 2; w++) begin
            rst_n[w] = 1'b0; scan_en[w] = 1'b0; scan_in[w] = 1'b0;
            sram_load[w] = 1'b0; gcsb[w] = 1'b1; err_clr[w] = 1'b0;
        end
        f_write = mk(4'd2, 16'd1, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF,
                           16'd0, 32'd0,        1'b1, 1'b1, 4'h0);
        f_read  = mk(4'd0, 16'd1, 32'h11111111, 1'b0, 1'b1, 4'h0,
                           16'd2, 32'h22222222, 1'b0, 1'b1, 4'h0);
        repeat (2) @(negedge clk);

        // Reset state
        for (int w = 0; w < 2; w++) begin
            chk("rst_csb",  csb_o[w], 2'b11);
            chk("rst_web",  web_o[w], 2'b11);
            chk("rst_busy", busy[w], 1'b0);
            chk("rst_acnt", acnt[w], 16'd0);
            chk("rst_sout", scan_out[w], 1'b0);
            chk("rst_addr", addr_o[w], 32'd0);
            chk("rst_errf", errf[w], 1'b0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);

        // Incomplete frame: trigger flags err_frame, no access
        shift_in(0, f_write, 50);
        pulse_csb(0);
        @(negedge clk);
        chk("short_errf", errf[0], 1'b1);
        chk("short_csb",  csb_o[0], 2'b11);
        chk("short_busy", busy[0], 1'b0);
        @(negedge clk);
        chk("short_acnt", acnt[0], 16'd0);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        chk("errclr", errf[0], 1'b0);

        // Write access
        shift_in(0, f_write, 112);
        pulse_csb(0);
        @(negedge clk);
        chk("wr_csb",   csb_o[0], 2'b10);
        chk("wr_web0",  web_o[0][0], 1'b0);
        chk("wr_addr0", addr_o[0][15:0], 16'd1);
        chk("wr_din0",  din_o[0][31:0], 32'hDEADBEEF);
        chk("wr_sel",   sel_o[0], 4'd2);
        chk("wr_mask0", wmask_o[0][3:0], 4'hF);
        chk("wr_busy",  busy[0], 1'b1);
        @(negedge clk);
        chk("wr_csb_after", csb_o[0], 2'b11);
        chk("wr_busy_cap",  busy[0], 1'b1);
        @(negedge clk);
        chk("wr_idle", busy[0], 1'b0);
        chk("wr_acnt", acnt[0], 16'd1);
        chk("wr_sel_hold", sel_o[0], 4'd2);

        // Read access with manual load
        shift_in(0, f_read, 112);
        pulse_csb(0);
        @(negedge clk);
        chk("rd_csb",  csb_o[0], 2'b00);
        chk("rd_web",  web_o[0], 2'b11);
        chk("rd_addr", addr_o[0], {16'd2, 16'd1});
        @(negedge clk);
        @(negedge clk);
        chk("rd_acnt", acnt[0], 16'd2);
        sram_load[0] = 1'b1;
        @(negedge clk);
        sram_load[0] = 1'b0;
        read_out(0, got_f);
        exp_f = mk(4'd0, 16'd1, 32'h00000001, 1'b0, 1'b1, 4'h0,
                         16'd2, 32'h00000008, 1'b0, 1'b1, 4'h0);
        chk("rd_frame", got_f, exp_f);

        // READ_LAT=3 auto-load, scan_en while busy
        shift_in(1, f_read, 112);
        pulse_csb(1);
        @(negedge clk);
        chk("al_csb",   csb_o[1], 2'b00);
        chk("al_busy1", busy[1], 1'b1);
        scan_en[1] = 1'b1;
        scan_in[1] = 1'b1;
        @(negedge clk);
        scan_en[1] = 1'b0;
        scan_in[1] = 1'b0;
        chk("al_busy2", busy[1], 1'b1);
        chk("al_errb",  errb[1], 1'b1);
        @(negedge clk);
        chk("al_busy3", busy[1], 1'b1);
        @(negedge clk);
        chk("al_busy4", busy[1], 1'b1);
        @(negedge clk);
        chk("al_idle", busy[1], 1'b0);
        chk("al_acnt", acnt[1], 16'd1);
        read_out(1, got_f);
        chk("al_frame", got_f, exp_f);

        // Reset in WAIT aborts the access
        pulse_csb(1);
        @(negedge clk);
        @(negedge clk);
        chk("ab_busy_wait", busy[1], 1'b1);
        rst_n[1] = 1'b0;
        #1;
        chk("ab_csb",  csb_o[1], 2'b11);
        chk("ab_busy", busy[1], 1'b0);
        chk("ab_acnt", acnt[1], 16'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("ab_acnt_after", acnt[1], 16'd0);
        chk("ab_busy_after", busy[1], 1'b0);

        // access_cnt wrap: back-to-back accesses every 3 cycles
        for (int i = 0; i < 65533; i++) begin
            gcsb[0] = 1'b0;
            @(negedge clk);
            gcsb[0] = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end
        @(negedge clk);
        chk("wrap_ffff", acnt[0], 16'hFFFF);
        pulse_csb(0);
        repeat (3) @(negedge clk);
        chk("wrap_zero", acnt[0], 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
